// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready flow control.
// Ports: clk/rst, in_valid/in_ready + a,b,cin,sub,tag in; out_valid/out_ready + sum,cout,ovf,tag_out out.
module sklansky_pipe_adder #(
  parameter int WIDTH      = 128,
  parameter int PIPE_EVERY = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  // Index 0 is the input register; index k holds the result of prefix group k.
  logic             v_q  [0:NSTG];
  logic [WIDTH-1:0] g_q  [0:NSTG];
  logic [WIDTH-1:0] p_q  [0:NSTG];
  logic [WIDTH-1:0] pp_q [0:NSTG];
  logic             c0_q [0:NSTG];
  logic [TAG_W-1:0] t_q  [0:NSTG];

  logic [WIDTH-1:0] gn [1:NSTG];
  logic [WIDTH-1:0] pn [1:NSTG];
  logic [WIDTH-1:0] gt;
  logic [WIDTH-1:0] pt;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] gf;
  logic             adv;
  int               j;

  assign adv      = ~v_q[NSTG] | out_ready;
  assign in_ready = adv;
  assign bx       = sub ? ~b : b;

  always_comb begin
    gt = '0;
    pt = '0;
    j  = 0;
    for (int k = 1; k <= NSTG; k++) begin
      gt = g_q[k-1];
      pt = p_q[k-1];
      // Carry-in acts as bit -1: one grey cell merges it into bit 0
      // so every prefix span ending at bit 0 already includes it.
      if (k == 1) begin
        gt[0] = gt[0] | (pt[0] & c0_q[0]);
        pt[0] = 1'b0;
      end
      for (int l = 1; l <= LEVELS; l++) begin
        if ((l - 1) / PIPE_EVERY == k - 1) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (i[l-1]) begin
              // j has bit l-1 clear, so it is not updated at this level.
              j     = ((i >> (l - 1)) << (l - 1)) - 1;
              gt[i] = gt[i] | (pt[i] & gt[j]);
              pt[i] = pt[i] & pt[j];
            end
          end
        end
      end
      gn[k] = gt;
      pn[k] = pt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NSTG; k++) begin
        v_q[k]  <= 1'b0;
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        pp_q[k] <= '0;
        c0_q[k] <= 1'b0;
        t_q[k]  <= '0;
      end
    end else if (adv) begin
      v_q[0]  <= in_valid;
      g_q[0]  <= a & bx;
      p_q[0]  <= a ^ bx;
      pp_q[0] <= a ^ bx;
      c0_q[0] <= cin ^ sub;
      t_q[0]  <= tag;
      for (int k = 1; k <= NSTG; k++) begin
        v_q[k]  <= v_q[k-1];
        g_q[k]  <= gn[k];
        p_q[k]  <= pn[k];
        pp_q[k] <= pp_q[k-1];
        c0_q[k] <= c0_q[k-1];
        t_q[k]  <= t_q[k-1];
      end
    end
  end

  assign gf        = g_q[NSTG];
  assign out_valid = v_q[NSTG];
  assign sum       = pp_q[NSTG] ^ {gf[WIDTH-2:0], c0_q[NSTG]};
  assign cout      = gf[WIDTH-1];
  assign ovf       = gf[WIDTH-2] ^ gf[WIDTH-1];
  assign tag_out   = t_q[NSTG];

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Self-checking bench for sklansky_pipe_adder.
// WIDTH=8 directed table plus WIDTH=37/PIPE_EVERY=2 flow, reset and random runs.
module tb_sklansky_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- WIDTH=8 instance ----------------
  logic       e_iv = 0, e_ir, e_ci = 0, e_sb = 0, e_ov, e_or = 1, e_co, e_of;
  logic [7:0] e_a = 0, e_b = 0, e_s;
  logic [3:0] e_t = 0, e_to;

  sklansky_pipe_adder #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir),
    .a(e_a), .b(e_b), .cin(e_ci), .sub(e_sb), .tag(e_t),
    .out_valid(e_ov), .out_ready(e_or), .sum(e_s), .cout(e_co),
    .ovf(e_of), .tag_out(e_to));

  // ---------------- WIDTH=37 instance ----------------
  logic        w_iv = 0, w_ir, w_ci = 0, w_sb = 0, w_ov, w_or = 1, w_co, w_of;
  logic [36:0] w_a = 0, w_b = 0, w_s;
  logic [4:0]  w_t = 0, w_to;

  sklansky_pipe_adder #(.WIDTH(37), .PIPE_EVERY(2), .TAG_W(5)) u37 (
    .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir),
    .a(w_a), .b(w_b), .cin(w_ci), .sub(w_sb), .tag(w_t),
    .out_valid(w_ov), .out_ready(w_or), .sum(w_s), .cout(w_co),
    .ovf(w_of), .tag_out(w_to));

  typedef struct {
    logic [7:0] a, b;
    logic       ci, sb;
    logic [7:0] s;
    logic       c, o;
  } vec_t;

  typedef struct {
    logic [36:0] s;
    logic        c, o;
    logic [4:0]  t;
  } exp_t;

  exp_t        q[$];
  bit          stalled = 0;
  logic [44:0] held;

  function automatic exp_t model37(input logic [36:0] a, b,
                                   input logic ci, sb, input logic [4:0] tg);
    logic [37:0] r;
    logic [36:0] bb;
    exp_t e;
    bb  = sb ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {37'd0, ci ^ sb};
    e.s = r[36:0];
    e.c = r[37];
    e.o = (a[36] == bb[36]) && (r[36] != a[36]);
    e.t = tg;
    return e;
  endfunction

  // One cycle on u37: drive at negedge, check outputs, update scoreboard.
  task automatic step(input logic iv, input logic ordy,
                      input logic [36:0] a, b, input logic ci, sb,
                      input logic [4:0] tg);
    exp_t e;
    @(negedge clk);
    if (stalled)
      chk({w_ov, w_s, w_co, w_of, w_to} == held, "frozen",
          64'({w_ov, w_s, w_co, w_of, w_to}), 64'(held));
    w_iv = iv; w_or = ordy; w_a = a; w_b = b;
    w_ci = ci; w_sb = sb; w_t = tg;
    #1;
    chk(w_ir == (!w_ov || ordy), "in_ready", 64'(w_ir), 64'(!w_ov || ordy));
    if (w_ov && ordy) begin
      if (q.size() == 0) begin
        chk(1'b0, "spurious_out", 64'(w_to), 64'd0);
      end else begin
        e = q.pop_front();
        chk(w_s == e.s, "sum37", 64'(w_s), 64'(e.s));
        chk({w_co, w_of} == {e.c, e.o}, "cout_ovf37",
            64'({w_co, w_of}), 64'({e.c, e.o}));
        chk(w_to == e.t, "tag37", 64'(w_to), 64'(e.t));
      end
    end
    stalled = w_ov && !ordy;
    held    = {w_ov, w_s, w_co, w_of, w_to};
    if (iv && w_ir) q.push_back(model37(a, b, ci, sb, tg));
  endtask

  vec_t tv[10];
  int   cnt;

  initial begin
    tv[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tv[2] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    tv[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tv[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tv[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tv[7] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tv[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[9] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({e_ov, e_s, e_co, e_of, e_to} == 15'd0, "reset_out8",
        64'({e_ov, e_s, e_co, e_of, e_to}), 64'd0);
    chk(e_ir == 1'b1, "reset_in_ready8", 64'(e_ir), 64'd1);
    chk({w_ov, w_s, w_to} == 43'd0, "reset_out37",
        64'({w_ov, w_s, w_to}), 64'd0);

    // Directed table, one op at a time, latency checked on the first.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e_a = tv[i].a; e_b = tv[i].b; e_ci = tv[i].ci; e_sb = tv[i].sb;
      e_t = 4'(i); e_iv = 1'b1; e_or = 1'b1;
      @(posedge clk);
      #1;
      e_iv = 1'b0;
      cnt = 0;
      while (!e_ov && cnt < 20) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      if (i == 0) chk(cnt == 3, "latency8", 64'(cnt), 64'd3);
      chk(e_ov == 1'b1, "valid8", 64'(e_ov), 64'd1);
      chk(e_s == tv[i].s, "sum8", 64'(e_s), 64'(tv[i].s));
      chk(e_co == tv[i].c, "cout8", 64'(e_co), 64'(tv[i].c));
      chk(e_of == tv[i].o, "ovf8", 64'(e_of), 64'(tv[i].o));
      chk(e_to == 4'(i), "tag8", 64'(e_to), 64'(i));
    end

    // 20 back-to-back ops, out_ready pattern 1,0,0,1.
    for (int i = 0; i < 20; i++)
      step(1'b1, (i % 4 == 0) || (i % 4 == 3), 37'($urandom) << 5,
           37'($urandom), i[0], i[1], 5'(i));
    cnt = 0;
    while (q.size() != 0 && cnt < 40) begin
      step(1'b0, (cnt % 4 == 0) || (cnt % 4 == 3), '0, '0, 1'b0, 1'b0, '0);
      cnt++;
    end
    chk(q.size() == 0, "tags_drained", 64'(q.size()), 64'd0);

    // Fill with 4 ops under stall, then reset mid-flight.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 37'(i + 1), 37'd3, 1'b0, 1'b0, 5'(i + 20));
    @(negedge clk);
    rst = 1'b1; w_iv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(w_ov == 1'b0, "rst_valid", 64'(w_ov), 64'd0);
    chk({w_s, w_to} == 42'd0, "rst_data", 64'({w_s, w_to}), 64'd0);
    q.delete();
    stalled = 0;
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, '0);

    // Boundary: all-ones add with carry, and full-width borrow.
    step(1'b1, 1'b1, {37{1'b1}}, 37'd0, 1'b1, 1'b0, 5'd1);
    step(1'b1, 1'b1, 37'd0, 37'd1, 1'b0, 1'b1, 5'd2);
    step(1'b1, 1'b1, {1'b0, {36{1'b1}}}, 37'd1, 1'b0, 1'b0, 5'd3);

    // Random traffic with random valid/ready.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           {5'($urandom), $urandom}, {5'($urandom), $urandom},
           1'($urandom), 1'($urandom), 5'($urandom));
    cnt = 0;
    while (q.size() != 0 && cnt < 40) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, '0);
      cnt++;
    end
    chk(q.size() == 0, "random_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
